// File: rtl/mmio_bus_if.sv
// Core-side and peripheral-side signal bundle of the MMIO interconnect.
// The slave modport is the interconnect's view. The master modport is the
// view of the environment, which is the core and the peripherals together.
interface mmio_bus_if #(
    parameter int unsigned N_SLOTS = 8
);
    // core side
    logic                   re;
    logic                   we;
    logic [14:0]            addr;
    logic [7:0]             data_write;
    logic [7:0]             data_read;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [7:0]             err_cnt;
    logic                   overrun;
    // peripheral side
    logic [N_SLOTS-1:0]     per_sel;
    logic [N_SLOTS-1:0]     per_re;
    logic [N_SLOTS-1:0]     per_we;
    logic [7:0]             per_addr;
    logic [7:0]             per_wdata;
    logic [8*N_SLOTS-1:0]   per_rdata;
    logic [N_SLOTS-1:0]     per_ack;

    modport slave (
        input  re, we, addr, data_write, per_rdata, per_ack,
        output data_read, busy, done, err, err_cnt, overrun,
        output per_sel, per_re, per_we, per_addr, per_wdata
    );

    modport master (
        output re, we, addr, data_write, per_rdata, per_ack,
        input  data_read, busy, done, err, err_cnt, overrun,
        input  per_sel, per_re, per_we, per_addr, per_wdata
    );
endinterface

// File: rtl/mmio_bus.sv
// Memory-mapped I/O interconnect: decodes one 256-byte page per slot.
// A slot is either fixed-latency or handshaked with a timeout. Every access
// ends with a done pulse, and unmapped or timed-out accesses also pulse err.
module mmio_bus #(
    parameter int unsigned N_SLOTS       = 8,
    parameter int unsigned BASE_PAGE     = 0,
    parameter logic [31:0] FAST_MASK     = 32'h0000_00F7,
    parameter int unsigned TIMEOUT       = 255,
    parameter logic [7:0]  UNMAPPED_DATA = 8'hFF
) (
    input logic        clk,
    input logic        rst_n,
    mmio_bus_if.slave  bus
);
    localparam logic [7:0] PAGE_LO  = 8'(BASE_PAGE);
    localparam logic [7:0] PAGE_HI  = 8'(BASE_PAGE + N_SLOTS);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [6:0]  slot_q, slot_d;
    logic        mapped_q, mapped_d;
    logic        is_wr_q, is_wr_d;
    logic        flag_q, flag_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [7:0]  per_addr_q, per_addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  data_read_q, data_read_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        overrun_q, overrun_d;

    logic [7:0]         req_page;
    logic               req_mapped;
    logic [6:0]         req_slot;
    logic [N_SLOTS-1:0] sel_vec;
    logic               ack_sel;
    logic               fast_sel;
    logic [7:0]         rdata_sel;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign req_page   = {1'b0, bus.addr[14:8]};
    assign req_mapped = (req_page >= PAGE_LO) && (req_page < PAGE_HI);
    assign req_slot   = bus.addr[14:8] - PAGE_LO[6:0];

    // Demultiplex the latched slot into a one-hot select and pick its ack/rdata/kind
    always_comb begin
        sel_vec   = '0;
        ack_sel   = 1'b0;
        fast_sel  = 1'b0;
        rdata_sel = 8'h00;
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            if (mapped_q && (slot_q == 7'(i))) begin
                sel_vec[i] = 1'b1;
                ack_sel    = bus.per_ack[i];
                fast_sel   = FAST_MASK[i];
                rdata_sel  = bus.per_rdata[8*i +: 8];
            end
        end
    end

    // Next-state logic for the access FSM and its bookkeeping registers
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        mapped_d    = mapped_q;
        is_wr_d     = is_wr_q;
        flag_d      = flag_q;
        tcnt_d      = tcnt_q;
        per_addr_d  = per_addr_q;
        wdata_d     = wdata_q;
        data_read_d = data_read_q;
        err_cnt_d   = err_cnt_q;
        overrun_d   = overrun_q;

        // a request that arrives outside IDLE is dropped, but it is remembered
        if ((state_q != IDLE) && (bus.re || bus.we)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.re || bus.we) begin
                    // we wins when both strobes are high
                    is_wr_d    = bus.we;
                    mapped_d   = req_mapped;
                    slot_d     = req_slot;
                    per_addr_d = bus.addr[7:0];
                    wdata_d    = bus.data_write;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                tcnt_d  = 8'h00;
                flag_d  = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                tcnt_d = tcnt_q + 8'd1;
                if (!mapped_q) begin
                    flag_d  = 1'b1;
                    state_d = DONE;
                end else if (fast_sel || ack_sel) begin
                    state_d = DONE;
                end else if (tcnt_q == TMO_LAST) begin
                    flag_d  = 1'b1;
                    state_d = DONE;
                end
                if ((state_d == DONE) && !is_wr_q) begin
                    data_read_d = flag_d ? UNMAPPED_DATA : rdata_sel;
                end
            end
            DONE: begin
                if (flag_q) begin
                    err_cnt_d = sat_inc8(err_cnt_q);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            mapped_q    <= 1'b0;
            is_wr_q     <= 1'b0;
            flag_q      <= 1'b0;
            tcnt_q      <= 8'h00;
            per_addr_q  <= 8'h00;
            wdata_q     <= 8'h00;
            data_read_q <= 8'h00;
            err_cnt_q   <= 8'h00;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            mapped_q    <= mapped_d;
            is_wr_q     <= is_wr_d;
            flag_q      <= flag_d;
            tcnt_q      <= tcnt_d;
            per_addr_q  <= per_addr_d;
            wdata_q     <= wdata_d;
            data_read_q <= data_read_d;
            err_cnt_q   <= err_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.busy      = (state_q == ACCESS) || (state_q == WAIT);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = (state_q == DONE) && flag_q;
    assign bus.per_sel   = bus.busy ? sel_vec : '0;
    assign bus.per_re    = ((state_q == ACCESS) && !is_wr_q) ? sel_vec : '0;
    assign bus.per_we    = ((state_q == ACCESS) &&  is_wr_q) ? sel_vec : '0;
    assign bus.per_addr  = per_addr_q;
    assign bus.per_wdata = wdata_q;
    assign bus.data_read = data_read_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_mmio_bus.sv
// Directed bench for mmio_bus with the default 8-slot configuration.
module tb_mmio_bus;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   cyc;

    always #5 clk = ~clk;

    mmio_bus_if #(.N_SLOTS(8)) bus ();

    mmio_bus #(
        .N_SLOTS(8), .BASE_PAGE(0), .FAST_MASK(32'h0000_00F7),
        .TIMEOUT(255), .UNMAPPED_DATA(8'hFF)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.re         = 1'b0;
        bus.we         = 1'b0;
        bus.addr       = 15'h0000;
        bus.data_write = 8'h00;
        bus.per_ack    = 8'h00;
        bus.per_rdata  = {8'h17, 8'h16, 8'h15, 8'h14, 8'h77, 8'h12, 8'h11, 8'h5A};
        step();
        step();
        chk("rst_data_read", 32'(bus.data_read), 32'h00);
        chk("rst_err_cnt",   32'(bus.err_cnt),   32'h00);
        chk("rst_overrun",   32'(bus.overrun),   32'h0);
        chk("rst_busy",      32'(bus.busy),      32'h0);
        chk("rst_per_sel",   32'(bus.per_sel),   32'h00);
        rst_n = 1'b1;
        step();

        // fast read of slot 0
        bus.re = 1'b1; bus.addr = 15'h0012;
        step();                                   // cycle 1
        bus.re = 1'b0;
        chk("rd0_per_re_c1",  32'(bus.per_re),   32'h01);
        chk("rd0_per_sel_c1", 32'(bus.per_sel),  32'h01);
        chk("rd0_per_addr",   32'(bus.per_addr), 32'h12);
        chk("rd0_busy_c1",    32'(bus.busy),     32'h1);
        step();                                   // cycle 2
        chk("rd0_per_re_c2",  32'(bus.per_re),   32'h00);
        chk("rd0_done_c2",    32'(bus.done),     32'h0);
        step();                                   // cycle 3
        chk("rd0_done_c3",    32'(bus.done),     32'h1);
        chk("rd0_data",       32'(bus.data_read), 32'h5A);
        chk("rd0_err",        32'(bus.err),      32'h0);
        step();                                   // cycle 4
        chk("rd0_done_c4",    32'(bus.done),     32'h0);
        chk("rd0_busy_c4",    32'(bus.busy),     32'h0);

        // handshaked write to slot 3, ack in the 4th WAIT cycle
        bus.we = 1'b1; bus.addr = 15'h0344; bus.data_write = 8'hC3;
        step();                                   // cycle 1
        bus.we = 1'b0;
        chk("wr3_per_we",    32'(bus.per_we),    32'h08);
        chk("wr3_per_re",    32'(bus.per_re),    32'h00);
        chk("wr3_per_wdata", 32'(bus.per_wdata), 32'hC3);
        chk("wr3_per_addr",  32'(bus.per_addr),  32'h44);
        step();                                   // cycle 2 (WAIT 1)
        chk("wr3_per_we_c2", 32'(bus.per_we),    32'h00);
        chk("wr3_sel_c2",    32'(bus.per_sel),   32'h08);
        step();                                   // cycle 3 (WAIT 2)
        bus.per_ack = 8'hF7;                      // acks of other slots
        step();                                   // cycle 4 (WAIT 3)
        bus.per_ack = 8'h00;
        chk("wr3_foreign_ack", 32'(bus.done),    32'h0);
        chk("wr3_sel_c4",      32'(bus.per_sel), 32'h08);
        step();                                   // cycle 5 (WAIT 4)
        bus.per_ack = 8'h08;
        chk("wr3_done_c5",   32'(bus.done),      32'h0);
        step();                                   // cycle 6
        bus.per_ack = 8'h00;
        chk("wr3_done_c6",   32'(bus.done),      32'h1);
        chk("wr3_err",       32'(bus.err),       32'h0);
        chk("wr3_data_keep", 32'(bus.data_read), 32'h5A);
        step();

        // read of slot 3 with no ack: timeout
        bus.re = 1'b1; bus.addr = 15'h0300;
        step();                                   // cycle 1
        bus.re = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 400) begin
            step();
            cyc++;
        end
        chk("tmo_done_cycle", 32'(cyc),           32'd257);
        chk("tmo_err",        32'(bus.err),       32'h1);
        chk("tmo_data",       32'(bus.data_read), 32'hFF);
        step();
        chk("tmo_err_cnt",    32'(bus.err_cnt),   32'h01);
        chk("tmo_sel_drop",   32'(bus.per_sel),   32'h00);

        // fast read of slot 5 so the next unmapped read visibly changes data
        bus.re = 1'b1; bus.addr = 15'h05A0;
        step();
        bus.re = 1'b0;
        step();
        step();                                   // cycle 3
        chk("rd5_data",       32'(bus.data_read), 32'h15);
        step();

        // unmapped read (page 9)
        bus.re = 1'b1; bus.addr = 15'h0900;
        step();                                   // cycle 1
        bus.re = 1'b0;
        chk("unm_sel",        32'(bus.per_sel),   32'h00);
        chk("unm_re",         32'(bus.per_re),    32'h00);
        chk("unm_busy",       32'(bus.busy),      32'h1);
        step();                                   // cycle 2
        chk("unm_sel_c2",     32'(bus.per_sel),   32'h00);
        step();                                   // cycle 3
        chk("unm_done",       32'(bus.done),      32'h1);
        chk("unm_err",        32'(bus.err),       32'h1);
        chk("unm_data",       32'(bus.data_read), 32'hFF);
        step();
        chk("unm_err_cnt",    32'(bus.err_cnt),   32'h02);
        chk("unm_overrun",    32'(bus.overrun),   32'h0);

        // re and we together to slot 1, then a request while busy
        bus.re = 1'b1; bus.we = 1'b1; bus.addr = 15'h0122; bus.data_write = 8'h9E;
        step();                                   // cycle 1
        bus.we = 1'b0; bus.addr = 15'h0500;       // re stays high: dropped request
        chk("both_per_we",    32'(bus.per_we),    32'h02);
        chk("both_per_re",    32'(bus.per_re),    32'h00);
        chk("both_wdata",     32'(bus.per_wdata), 32'h9E);
        step();                                   // cycle 2
        bus.re = 1'b0;
        chk("ovr_set",        32'(bus.overrun),   32'h1);
        step();                                   // cycle 3
        chk("both_done",      32'(bus.done),      32'h1);
        chk("both_data_keep", 32'(bus.data_read), 32'hFF);
        step();
        step();
        chk("drop_busy",      32'(bus.busy),      32'h0);
        chk("drop_sel",       32'(bus.per_sel),   32'h00);
        chk("ovr_sticky",     32'(bus.overrun),   32'h1);

        // reset during WAIT of a handshaked read
        bus.re = 1'b1; bus.addr = 15'h0301;
        step();
        bus.re = 1'b0;
        step();                                   // WAIT
        chk("rw_sel_wait",    32'(bus.per_sel),   32'h08);
        rst_n = 1'b0;
        #1;
        chk("rw_busy",        32'(bus.busy),      32'h0);
        chk("rw_sel",         32'(bus.per_sel),   32'h00);
        chk("rw_data",        32'(bus.data_read), 32'h00);
        chk("rw_err_cnt",     32'(bus.err_cnt),   32'h00);
        chk("rw_overrun",     32'(bus.overrun),   32'h0);
        step();
        rst_n = 1'b1;
        step();
        bus.re = 1'b1; bus.addr = 15'h0001;
        step();
        bus.re = 1'b0;
        chk("post_per_re",    32'(bus.per_re),    32'h01);
        step();
        step();
        chk("post_done",      32'(bus.done),      32'h1);
        chk("post_data",      32'(bus.data_read), 32'h5A);
        chk("post_err",       32'(bus.err),       32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
